// File: rtl/nv_minmax_pkg.sv
// Shared definitions for the min/max sequential reducer: mode encoding,
// FSM states and the flat-index width rule.
package nv_minmax_pkg;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Width needed to address every element of a full window (beats * lanes).
  function automatic int idx_width(input int beats, input int lanes);
    return (beats * lanes > 1) ? $clog2(beats * lanes) : 1;
  endfunction

endpackage

// File: rtl/nv_minmax_seq_reduce_if.sv
// Beat input, configuration and result output of the min/max window reducer.
interface nv_minmax_seq_reduce_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4,
  parameter int MAX_BEATS  = 16,
  parameter int BEAT_W     = $clog2(MAX_BEATS),
  parameter int IDX_W      = nv_minmax_pkg::idx_width(MAX_BEATS, NUM_INPUTS)
);

  logic                        cfg_min_max;
  logic [BEAT_W-1:0]           cfg_beats;
  logic                        in_pvld;
  logic                        in_prdy;
  logic [NUM_INPUTS*WIDTH-1:0] in_pd;
  logic                        out_pvld;
  logic                        out_prdy;
  logic [WIDTH-1:0]            out_value;
  logic [IDX_W-1:0]            out_index;

  modport master (
    output cfg_min_max, cfg_beats, in_pvld, in_pd, out_prdy,
    input  in_prdy, out_pvld, out_value, out_index
  );

  modport slave (
    input  cfg_min_max, cfg_beats, in_pvld, in_pd, out_prdy,
    output in_prdy, out_pvld, out_value, out_index
  );

endinterface

// File: rtl/DW_minmax.sv
// Combinational lane reducer: returns the min or max of num_inputs elements
// and its lane. Max keeps the last occurrence of a tie, min keeps the first.
module DW_minmax #(
  parameter int width      = 8,
  parameter int num_inputs = 4,
  localparam int INDEX_W   = (num_inputs > 1) ? $clog2(num_inputs) : 1
) (
  input  logic [num_inputs*width-1:0] a,
  input  logic                        tc,
  input  logic                        min_max,
  output logic [width-1:0]            value,
  output logic [INDEX_W-1:0]          index
);

  function automatic logic less(input logic [width-1:0] x,
                                input logic [width-1:0] y,
                                input logic             tc_i);
    logic signed [width-1:0] sx;
    logic signed [width-1:0] sy;
    sx = x;
    sy = y;
    return tc_i ? (sx < sy) : (x < y);
  endfunction

  logic [width-1:0] elem;

  always_comb begin
    value = a[width-1:0];
    index = '0;
    elem  = '0;
    for (int i = 1; i < num_inputs; i++) begin
      elem = a[i*width +: width];
      if (min_max ? !less(elem, value, tc) : less(elem, value, tc)) begin
        value = elem;
        index = INDEX_W'(i);
      end
    end
  end

endmodule

// File: rtl/nv_minmax_seq_reduce.sv
// Folds per-beat DW_minmax results over a window of cfg_beats+1 beats and
// presents the window extreme and its flat element index on a valid/ready port.
module nv_minmax_seq_reduce #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  nv_minmax_seq_reduce_if.slave bus
);

  import nv_minmax_pkg::*;

  localparam int BEAT_W = $clog2(MAX_BEATS);
  localparam int IDX_W  = idx_width(MAX_BEATS, NUM_INPUTS);
  localparam int LANE_W = $clog2(NUM_INPUTS);

  state_t            state;
  logic              first;
  logic [BEAT_W-1:0] beat_cnt;
  logic              mode_q;
  logic [BEAT_W-1:0] beats_q;
  logic [WIDTH-1:0]  acc_val;
  logic [IDX_W-1:0]  acc_idx;
  logic              out_pvld_q;
  logic [WIDTH-1:0]  out_value_q;
  logic [IDX_W-1:0]  out_index_q;

  logic              mode_eff;
  logic [BEAT_W-1:0] beats_eff;
  logic [WIDTH-1:0]  bval;
  logic [LANE_W-1:0] blane;
  logic [IDX_W-1:0]  cand_idx;
  logic              take;
  logic              accept;
  logic              last_beat;
  logic [WIDTH-1:0]  nxt_val;
  logic [IDX_W-1:0]  nxt_idx;

  DW_minmax #(
    .width      (WIDTH),
    .num_inputs (NUM_INPUTS)
  ) u_lane_minmax (
    .a       (bus.in_pd),
    .tc      (1'b0),
    .min_max (mode_eff),
    .value   (bval),
    .index   (blane)
  );

  // On a window's first beat the live cfg drives the reduction, later beats use the latched copy.
  always_comb begin
    mode_eff  = first ? bus.cfg_min_max : mode_q;
    beats_eff = first ? bus.cfg_beats   : beats_q;
    accept    = bus.in_pvld && (state == ST_ACC);
    cand_idx  = IDX_W'(beat_cnt) * IDX_W'(NUM_INPUTS) + IDX_W'(blane);
    take      = first || ((mode_eff == MODE_MAX) ? (bval >= acc_val) : (bval < acc_val));
    nxt_val   = take ? bval     : acc_val;
    nxt_idx   = take ? cand_idx : acc_idx;
    last_beat = (beat_cnt == beats_eff);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state       <= ST_ACC;
      first       <= 1'b1;
      beat_cnt    <= '0;
      mode_q      <= MODE_MIN;
      beats_q     <= '0;
      acc_val     <= '0;
      acc_idx     <= '0;
      out_pvld_q  <= 1'b0;
      out_value_q <= '0;
      out_index_q <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (first) begin
              mode_q  <= bus.cfg_min_max;
              beats_q <= bus.cfg_beats;
            end
            acc_val <= nxt_val;
            acc_idx <= nxt_idx;
            if (last_beat) begin
              out_value_q <= nxt_val;
              out_index_q <= nxt_idx;
              out_pvld_q  <= 1'b1;
              state       <= ST_HOLD;
              beat_cnt    <= '0;
              first       <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              first    <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_prdy) begin
            out_pvld_q <= 1'b0;
            state      <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

  assign bus.in_prdy   = (state == ST_ACC);
  assign bus.out_pvld  = out_pvld_q;
  assign bus.out_value = out_value_q;
  assign bus.out_index = out_index_q;

endmodule

// File: tb/tb_nv_minmax_seq_reduce.sv
// Scoreboard bench for nv_minmax_seq_reduce: windows are modelled as a flat
// element scan and results are checked as they leave the output port.
module tb_nv_minmax_seq_reduce;
  import nv_minmax_pkg::*;

  localparam int WIDTH      = 8;
  localparam int NUM_INPUTS = 4;
  localparam int MAX_BEATS  = 16;
  localparam int BEAT_W     = 4;
  localparam int IDX_W      = 6;
  localparam int PD_W       = WIDTH * NUM_INPUTS;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic [IDX_W-1:0] index;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nv_minmax_seq_reduce_if #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .MAX_BEATS(MAX_BEATS)) bus ();

  nv_minmax_seq_reduce #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .MAX_BEATS(MAX_BEATS)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .bus             (bus)
  );

  res_t            sb[$];
  logic [PD_W-1:0] win[$];
  int              n_checks = 0;
  int              n_fail = 0;
  int              cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PD_W-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    logic [PD_W-1:0] p;
    p = {WIDTH'(e3), WIDTH'(e2), WIDTH'(e1), WIDTH'(e0)};
    return p;
  endfunction

  // Flat scan in element order: max keeps the last tie, min the first.
  function automatic res_t model(input logic mode, input logic [PD_W-1:0] beats[$]);
    res_t            r;
    logic [PD_W-1:0] pd;
    logic [WIDTH-1:0] v;
    int              flat;
    r = '0;
    for (int b = 0; b < beats.size(); b++) begin
      pd = beats[b];
      for (int l = 0; l < NUM_INPUTS; l++) begin
        v = pd[l*WIDTH +: WIDTH];
        flat = b * NUM_INPUTS + l;
        if (flat == 0 || (mode ? (v >= r.value) : (v < r.value))) begin
          r.value = v;
          r.index = IDX_W'(flat);
        end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (rst_n && bus.out_pvld && bus.out_prdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got value=%0d index=%0d, required no result", bus.out_value, bus.out_index);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (bus.out_value !== e.value) begin
          n_fail++;
          $display("FAIL sb_value: got %0d, required %0d", bus.out_value, e.value);
        end
        n_checks++;
        if (bus.out_index !== e.index) begin
          n_fail++;
          $display("FAIL sb_index: got %0d, required %0d", bus.out_index, e.index);
        end
      end
    end
  end

  task automatic send_beat(input logic [PD_W-1:0] pd, input logic mode, input logic [BEAT_W-1:0] beats);
    int n;
    n = 0;
    bus.in_pd       = pd;
    bus.cfg_min_max = mode;
    bus.cfg_beats   = beats;
    bus.in_pvld     = 1'b1;
    while (bus.in_prdy !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_prdy_timeout: in_prdy=%b after %0d cycles, required 1", bus.in_prdy, n);
    end
    @(posedge clk); #1;
    bus.in_pvld = 1'b0;
    win.push_back(pd);
  endtask

  task automatic end_window(input logic mode);
    sb.push_back(model(mode, win));
    win.delete();
  endtask

  task automatic send_window(input logic mode, input logic [BEAT_W-1:0] beats, input logic [PD_W-1:0] q[$]);
    for (int i = 0; i < q.size(); i++) send_beat(q[i], mode, beats);
    end_window(mode);
  endtask

  task automatic test_reset();
    bus.in_pvld = 1'b0; bus.in_pd = '0; bus.cfg_min_max = 1'b0; bus.cfg_beats = '0; bus.out_prdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.out_pvld !== 1'b0) begin n_fail++; $display("FAIL reset_out_pvld: got %b, required 0", bus.out_pvld); end
    n_checks++; if (bus.in_prdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_prdy: got %b, required 1", bus.in_prdy); end
    n_checks++; if (bus.out_value !== '0) begin n_fail++; $display("FAIL reset_out_value: got %0d, required 0", bus.out_value); end
    n_checks++; if (bus.out_index !== '0) begin n_fail++; $display("FAIL reset_out_index: got %0d, required 0", bus.out_index); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max_basic();
    bus.out_prdy = 1'b1;
    send_beat(pack4(1, 9, 2, 3), 1'b1, 4'd3);
    send_beat(pack4(4, 5, 6, 7), 1'b1, 4'd3);
    send_beat(pack4(0, 0, 0, 0), 1'b1, 4'd3);
    n_checks++; if (bus.out_pvld !== 1'b0) begin n_fail++; $display("FAIL basic_early_pvld: got %b, required 0", bus.out_pvld); end
    send_beat(pack4(8, 1, 1, 1), 1'b1, 4'd3);
    end_window(1'b1);
    n_checks++; if (bus.out_pvld !== 1'b1) begin n_fail++; $display("FAIL basic_latency_pvld: got %b, required 1", bus.out_pvld); end
    n_checks++; if (bus.in_prdy !== 1'b0) begin n_fail++; $display("FAIL basic_bubble_prdy: got %b, required 0", bus.in_prdy); end
    n_checks++; if (bus.out_value !== 8'd9) begin n_fail++; $display("FAIL basic_value: got %0d, required 9", bus.out_value); end
    n_checks++; if (bus.out_index !== 6'd1) begin n_fail++; $display("FAIL basic_index: got %0d, required 1", bus.out_index); end
    @(posedge clk); #1;
  endtask

  task automatic test_ties();
    logic [PD_W-1:0] q[$];
    bus.out_prdy = 1'b1;
    q = {};
    q.push_back(pack4(5, 5, 0, 0));
    q.push_back(pack4(0, 0, 5, 0));
    send_window(1'b1, 4'd1, q);
    n_checks++; if (bus.out_index !== 6'd6) begin n_fail++; $display("FAIL ties_max_index: got %0d, required 6", bus.out_index); end
    q = {};
    q.push_back(pack4(2, 7, 7, 7));
    q.push_back(pack4(7, 2, 7, 7));
    send_window(1'b0, 4'd1, q);
    n_checks++; if (bus.out_value !== 8'd2) begin n_fail++; $display("FAIL ties_min_value: got %0d, required 2", bus.out_value); end
    n_checks++; if (bus.out_index !== 6'd0) begin n_fail++; $display("FAIL ties_min_index: got %0d, required 0", bus.out_index); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [PD_W-1:0] q[$];
    res_t exp;
    bus.out_prdy = 1'b0;
    q = {};
    for (int i = 0; i < 3; i++) q.push_back(PD_W'($urandom));
    send_window(1'b1, 4'd2, q);
    exp = sb[sb.size()-1];
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.out_pvld !== 1'b1 || bus.out_value !== exp.value || bus.out_index !== exp.index || bus.in_prdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got pvld=%b value=%0d index=%0d in_prdy=%b, required pvld=1 value=%0d index=%0d in_prdy=0",
                 i, bus.out_pvld, bus.out_value, bus.out_index, bus.in_prdy, exp.value, exp.index);
      end
      @(posedge clk); #1;
    end
    bus.out_prdy = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.in_prdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_prdy: got %b, required 1", bus.in_prdy); end
    n_checks++; if (bus.out_pvld !== 1'b0) begin n_fail++; $display("FAIL bp_release_pvld: got %b, required 0", bus.out_pvld); end
    q = {};
    for (int i = 0; i < 2; i++) q.push_back(PD_W'($urandom));
    send_window(1'b0, 4'd1, q);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [PD_W-1:0] q[$];
    int c0;
    bus.out_prdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_pd = PD_W'($urandom);
      @(posedge clk); #1;
    end
    c0 = cyc;
    for (int w = 0; w < 4; w++) begin
      q = {};
      q.push_back(pack4(3, 1, 4, 1));
      send_window(1'b0, 4'd0, q);
      n_checks++;
      if (bus.out_value !== 8'd1 || bus.out_index !== 6'd1) begin
        n_fail++;
        $display("FAIL b2b_result w%0d: got value=%0d index=%0d, required value=1 index=1", w, bus.out_value, bus.out_index);
      end
    end
    n_checks++;
    if (cyc - c0 !== 7) begin n_fail++; $display("FAIL b2b_throughput: got %0d cycles, required 7", cyc - c0); end
    @(posedge clk); #1;
  endtask

  task automatic test_cfg_change();
    bus.out_prdy = 1'b1;
    send_beat(pack4(10, 20, 30, 40), 1'b1, 4'd3);
    send_beat(pack4(50, 3, 60, 70), 1'b0, 4'd0);
    send_beat(pack4(15, 25, 90, 35), 1'b1, 4'd1);
    n_checks++; if (bus.out_pvld !== 1'b0) begin n_fail++; $display("FAIL cfg_len_early: got pvld=%b, required 0", bus.out_pvld); end
    send_beat(pack4(5, 6, 7, 8), 1'b0, 4'd2);
    end_window(1'b1);
    n_checks++; if (bus.out_pvld !== 1'b1) begin n_fail++; $display("FAIL cfg_len_end: got pvld=%b, required 1", bus.out_pvld); end
    n_checks++; if (bus.out_value !== 8'd90) begin n_fail++; $display("FAIL cfg_latched_mode: got %0d, required 90", bus.out_value); end
    send_beat(pack4(40, 30, 20, 50), 1'b0, 4'd1);
    send_beat(pack4(60, 10, 70, 80), 1'b1, 4'd5);
    end_window(1'b0);
    n_checks++; if (bus.out_pvld !== 1'b1) begin n_fail++; $display("FAIL cfg_new_len: got pvld=%b, required 1", bus.out_pvld); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [PD_W-1:0] q[$];
    res_t dropped;
    bus.out_prdy = 1'b1;
    send_beat(pack4(200, 201, 202, 203), 1'b1, 4'd3);
    send_beat(pack4(1, 2, 3, 4), 1'b1, 4'd3);
    win.delete();
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_pvld !== 1'b0 || bus.in_prdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_ctrl: got pvld=%b in_prdy=%b, required 0/1", bus.out_pvld, bus.in_prdy); end
    n_checks++; if (bus.out_value !== '0) begin n_fail++; $display("FAIL rstmid_value: got %0d, required 0", bus.out_value); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q = {};
    q.push_back(pack4(9, 9, 9, 9));
    q.push_back(pack4(9, 9, 9, 9));
    q.push_back(pack4(9, 4, 9, 9));
    q.push_back(pack4(9, 9, 9, 9));
    send_window(1'b0, 4'd3, q);
    n_checks++; if (bus.out_value !== 8'd4 || bus.out_index !== 6'd9) begin n_fail++; $display("FAIL rstmid_fresh: got value=%0d index=%0d, required value=4 index=9", bus.out_value, bus.out_index); end
    @(posedge clk); #1;
    bus.out_prdy = 1'b0;
    q = {};
    q.push_back(pack4(11, 12, 13, 14));
    send_window(1'b1, 4'd0, q);
    n_checks++; if (bus.out_pvld !== 1'b1) begin n_fail++; $display("FAIL rsthold_pvld: got %b, required 1", bus.out_pvld); end
    dropped = sb.pop_back();
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_pvld !== 1'b0 || bus.out_index !== '0) begin n_fail++; $display("FAIL rsthold_clear: got pvld=%b index=%0d, required 0/0 (dropped %0d)", bus.out_pvld, bus.out_index, dropped.index); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_prdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [PD_W-1:0] q[$];
    logic            mode;
    int              nb;
    bus.out_prdy = 1'b1;
    for (int w = 0; w < 6; w++) begin
      mode = 1'($urandom_range(0, 1));
      nb = $urandom_range(0, 7);
      q = {};
      for (int b = 0; b <= nb; b++)
        q.push_back(pack4($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
      send_window(mode, BEAT_W'(nb), q);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_max_basic();
    test_ties();
    test_backpressure();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    test_random();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending results, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nv_minmax_seq_reduce.md
# nv_minmax_seq_reduce

Sequential min/max reduction stage that sits directly downstream of the combinational `DW_minmax` lane reducer in the pooling datapath. Each accepted beat carries NUM_INPUTS unsigned elements. The block reduces each beat with a `DW_minmax` instance and folds the per-beat result into a running accumulator over a configurable window of beats. At window end it presents the window's extreme value and its flat element index on a valid/ready output.

## Interface
- WIDTH, 8, element width in bits (unsigned).
- NUM_INPUTS, 4, elements per beat (2..64).
- MAX_BEATS, 16, maximum beats per window (power of two, ≥2).
- BEAT_W, derived: clog2(MAX_BEATS).
- IDX_W, derived: clog2(MAX_BEATS*NUM_INPUTS).

Ports:
- nvdla_core_clk, in, 1, sole clock.
- nvdla_core_rstn, in, 1, asynchronous active-low reset.
- cfg_min_max, in, 1, 0 = min and 1 = max; sampled on the first beat of a window.
- cfg_beats, in, BEAT_W, window length minus one; sampled on the first beat of a window.
- in_pvld, in, 1, input beat valid.
- in_prdy, out, 1, input beat ready.
- in_pd, in, NUM_INPUTS*WIDTH, packed elements; lane 0 is in the LSBs.
- out_pvld, out, 1, result valid.
- out_prdy, in, 1, result ready.
- out_value, out, WIDTH, window min or max.
- out_index, out, IDX_W, flat index equal to beat_number*NUM_INPUTS + lane.

## Operation
- States:
  - ACC: accumulating beats.
  - HOLD: result presented on the output.
- Reset (async assert, synchronous release) sets:
  - state=ACC, beat_cnt=0, first=1.
  - out_pvld=0, out_value=0, out_index=0.
  - accumulator value=0, accumulator index=0.
  - latched mode=0, latched beats=0.
- Input handshake: a beat is accepted when in_pvld && in_prdy. in_prdy = (state==ACC).
- Per accepted beat:
  - The `DW_minmax` instance (width=WIDTH, num_inputs=NUM_INPUTS, tc=0) yields bval and blane.
  - The candidate index is {beat_cnt, blane}, zero-extended or shifted as needed to form beat_cnt*NUM_INPUTS + blane.
- First beat of a window (first=1):
  - Latch cfg_min_max and cfg_beats.
  - Load the accumulator with the candidate unconditionally.
- Later beats:
  - Max mode: replace when bval >= acc. The last occurrence wins, consistent with the lane rule.
  - Min mode: replace when bval < acc. The first occurrence wins.
- Last beat (beat_cnt == latched beats; on the first beat, compare against cfg_beats):
  - Write the final accumulator result into out_value/out_index.
  - Set out_pvld=1, state→HOLD, beat_cnt→0, first→1.
- Otherwise: beat_cnt+1, first→0.
- HOLD: outputs are stable while out_pvld && !out_prdy. On out_pvld && out_prdy: out_pvld→0, state→ACC.
- cfg changes mid-window are ignored until the next window's first beat.
- cfg_beats=0 gives a single-beat window, equivalent to one `DW_minmax` result registered.
- Unsigned compares only. No signed support.

## Timing
- Latency: the last beat is accepted in cycle T; out_pvld=1 in cycle T+1.
- Throughput: one beat per cycle in ACC. There is one bubble per window: in_prdy=0 from T+1 until the cycle after the output handshake.
- Best case for N-beat windows: N+1 cycles per window when out_prdy is held high.
- in_prdy is a registered-state decode and has no combinational path from out_prdy.
- Output backpressure of any length holds out_value/out_index/out_pvld constant.
- in_pd may change without in_pvld. Nothing is sampled unless in_pvld && in_prdy.
- Reset asserted mid-window or in HOLD discards the partial or pending result immediately. The outputs take their reset values asynchronously.

## Structure
- Shared package `nv_minmax_pkg`: MIN/MAX mode encoding constants and the index-width derivation function (same ranges as the `DW_minmax` index rule, extended for beats).
- One sub-module instance: `DW_minmax` for the per-beat lane reduction. The accumulator, counter and FSM are local to this block.
- Estimated 150–250 lines of RTL.

## Test plan
- Max mode, cfg_beats=3, NUM_INPUTS=4, beats {1,9,2,3},{4,5,6,7},{0,0,0,0},{8,1,1,1} → out_value=9, out_index=1, out_pvld one cycle after the 4th beat.
- Ties, max mode, cfg_beats=1, beats {5,5,0,0},{0,0,5,0} → out_index=6 (last occurrence). Min mode, beats {2,7,7,7},{7,2,7,7} → out_value=2, out_index=0 (first occurrence).
- Backpressure: hold out_prdy=0 for 10 cycles after the result → outputs stable, in_prdy=0 throughout. Release out_prdy → in_prdy=1 on the next cycle and the next window accumulates correctly.
- cfg_beats=0, back-to-back beats {3,1,4,1} in min mode, out_prdy=1 → one result every 2 cycles, value=1, index=1.
- Toggle cfg_min_max and cfg_beats mid-window → the current window uses the values latched on its first beat. The new cfg applies from the next window.
- Assert nvdla_core_rstn=0 after 2 of 4 beats, then release → out_pvld=0. A fresh 4-beat window yields indexes counted from beat 0, with no residue from the aborted window.
